// File: rtl/eq_pkg.sv
// Shared constants for the CS4272 serial interface: frame-counter taps and
// the stereo sample container used by the receive and transmit paths.
package eq_pkg;

    localparam logic [9:0] RX_LFT_CAP = 10'h3EF;
    localparam logic [9:0] RX_RHT_CAP = 10'h1EF;
    localparam logic [9:0] TX_LFT_LD  = 10'h1FF;
    localparam logic [9:0] TX_RHT_LD  = 10'h3FF;

    localparam int unsigned MCLK_BIT  = 32'd1;
    localparam int unsigned SCLK_BIT  = 32'd4;
    localparam int unsigned LRCLK_BIT = 32'd9;

    // Sub-slot phases: last clk before SCLK rises, and last clk before it falls.
    localparam logic [4:0] RX_BIT_PH  = 5'h0F;
    localparam logic [4:0] TX_FALL_PH = 5'h1F;

    typedef struct packed {
        logic [15:0] lft;
        logic [15:0] rht;
    } stereo_t;

    function automatic logic at_phase(input logic [9:0] cnt, input logic [4:0] ph);
        return (cnt[4:0] == ph);
    endfunction

endpackage

// File: rtl/codec_intf.sv
// CS4272 serial interface: clock divider, codec reset release, SDout
// deserializer with frame-gated vld, and SDin serializer.
module codec_intf
    import eq_pkg::*;
#(
    parameter int FRAME_BITS = 10,
    parameter int SAMPLE_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] lft_in,
    input  logic [SAMPLE_W-1:0] rht_in,
    output logic [SAMPLE_W-1:0] lft_out,
    output logic [SAMPLE_W-1:0] rht_out,
    output logic                vld,
    output logic                MCLK,
    output logic                SCLK,
    output logic                LRCLK,
    output logic                RSTn,
    input  logic                SDout,
    output logic                SDin
);

    logic [FRAME_BITS-1:0] cnt_q, cnt_d;
    logic                  mclk_q, mclk_d;
    logic                  sclk_q, sclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  rstn_q, rstn_d;
    logic                  left_ok_q, left_ok_d;
    logic                  vld_q, vld_d;
    logic [SAMPLE_W-1:0]   rx_shift_q, rx_shift_d;
    logic [SAMPLE_W-1:0]   lft_hold_q, lft_hold_d;
    stereo_t               rx_out_q, rx_out_d;
    stereo_t               tx_hold_q, tx_hold_d;
    logic [SAMPLE_W-1:0]   tx_shift_q, tx_shift_d;

    logic                  wrap_s;
    logic                  rx_bit_s;
    logic                  tx_fall_s;
    logic                  lft_cap_s;
    logic                  rht_cap_s;
    logic                  tx_lft_ld_s;
    logic                  tx_rht_ld_s;
    logic [SAMPLE_W-1:0]   rx_word_s;

    // Counter-position strobes shared by all paths.
    always_comb begin
        wrap_s      = (cnt_q == TX_RHT_LD);
        rx_bit_s    = at_phase(cnt_q, RX_BIT_PH);
        tx_fall_s   = at_phase(cnt_q, TX_FALL_PH);
        lft_cap_s   = (cnt_q == RX_LFT_CAP);
        rht_cap_s   = (cnt_q == RX_RHT_CAP);
        tx_lft_ld_s = (cnt_q == TX_LFT_LD);
        tx_rht_ld_s = (cnt_q == TX_RHT_LD);
        rx_word_s   = {rx_shift_q[SAMPLE_W-2:0], SDout};
    end

    // Divider: codec clocks are taken from the next count so they are flop outputs aligned with cnt_q.
    always_comb begin
        cnt_d   = cnt_q + FRAME_BITS'(1);
        mclk_d  = cnt_d[MCLK_BIT];
        sclk_d  = cnt_d[SCLK_BIT];
        lrclk_d = cnt_d[LRCLK_BIT];
        if (wrap_s) begin
            rstn_d = 1'b1;
        end else begin
            rstn_d = rstn_q;
        end
    end

    // Receive shifter and left-word hold; left_ok marks a left word captured with the codec running.
    always_comb begin
        rx_shift_d = rx_shift_q;
        lft_hold_d = lft_hold_q;
        left_ok_d  = left_ok_q;
        if (rx_bit_s) begin
            rx_shift_d = rx_word_s;
        end else begin
            rx_shift_d = rx_shift_q;
        end
        if (lft_cap_s) begin
            lft_hold_d = rx_word_s;
            left_ok_d  = left_ok_q | rstn_q;
        end else begin
            lft_hold_d = lft_hold_q;
            left_ok_d  = left_ok_q;
        end
    end

    // Publish a stereo pair only once a full post-reset frame has been seen.
    always_comb begin
        rx_out_d = rx_out_q;
        vld_d    = 1'b0;
        if (rht_cap_s && left_ok_q) begin
            rx_out_d.lft = lft_hold_q;
            rx_out_d.rht = rx_word_s;
            vld_d        = 1'b1;
        end else begin
            rx_out_d = rx_out_q;
            vld_d    = 1'b0;
        end
    end

    // Transmit: latch at vld, load at slot start (load beats the coincident fall), shift on SCLK fall.
    always_comb begin
        tx_hold_d  = tx_hold_q;
        tx_shift_d = tx_shift_q;
        if (vld_q) begin
            tx_hold_d.lft = lft_in;
            tx_hold_d.rht = rht_in;
        end else begin
            tx_hold_d = tx_hold_q;
        end
        if (tx_lft_ld_s) begin
            tx_shift_d = tx_hold_q.lft;
        end else if (tx_rht_ld_s) begin
            tx_shift_d = tx_hold_q.rht;
        end else if (tx_fall_s) begin
            tx_shift_d = {tx_shift_q[SAMPLE_W-2:0], 1'b0};
        end else begin
            tx_shift_d = tx_shift_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            mclk_q     <= 1'b0;
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            rstn_q     <= 1'b0;
            left_ok_q  <= 1'b0;
            vld_q      <= 1'b0;
            rx_shift_q <= '0;
            lft_hold_q <= '0;
            rx_out_q   <= '0;
            tx_hold_q  <= '0;
            tx_shift_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            mclk_q     <= mclk_d;
            sclk_q     <= sclk_d;
            lrclk_q    <= lrclk_d;
            rstn_q     <= rstn_d;
            left_ok_q  <= left_ok_d;
            vld_q      <= vld_d;
            rx_shift_q <= rx_shift_d;
            lft_hold_q <= lft_hold_d;
            rx_out_q   <= rx_out_d;
            tx_hold_q  <= tx_hold_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    assign MCLK    = mclk_q;
    assign SCLK    = sclk_q;
    assign LRCLK   = lrclk_q;
    assign RSTn    = rstn_q;
    assign vld     = vld_q;
    assign lft_out = rx_out_q.lft;
    assign rht_out = rx_out_q.rht;
    assign SDin    = tx_shift_q[SAMPLE_W-1];

endmodule

// File: doc/codec_intf.md
Name: codec_intf

Overview:
- Serial interface between the Equalizer datapath and the CS4272 codec. Free-running divider generates MCLK, SCLK and LRCLK. Codec reset (RSTn) is released after one frame.
- Deserializes SDout into 16-bit left/right samples and flags each complete stereo frame with a one-cycle vld pulse.
- Serializes processed 16-bit samples from the band/volume stage onto SDin.
- Sits between the CS4272 pins and the filter/volume pipeline. Sample rate is clk/1024, which is 48828 Hz at 50 MHz.

Parameters:
- FRAME_BITS, 10, width of the frame counter; frame = 2^FRAME_BITS clk.
- SAMPLE_W, 16, bits per channel slot; fixed at 16 for FRAME_BITS=10.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; one clock, synchronous and active-low.
- lft_in  in  16  signed processed left sample to transmit.
- rht_in  in  16  signed processed right sample to transmit.
- lft_out  out  16  signed received left sample.
- rht_out  out  16  signed received right sample.
- vld  out  1  one-clk pulse: lft_out/rht_out updated, and lft_in/rht_in latched.
- MCLK  out  1  codec master clock, clk/4.
- SCLK  out  1  codec serial bit clock, clk/32.
- LRCLK  out  1  word clock, clk/1024; high = left slot.
- RSTn  out  1  codec reset, active-low.
- SDout  in  1  serial data from codec ADC.
- SDin  out  1  serial data to codec DAC.

Behaviour:
- cnt[9:0]:
  - Resets to 0 and increments every clk; wraps 0x3FF->0.
  - MCLK=cnt[1], SCLK=cnt[4], LRCLK=cnt[9], all registered so they are glitch-free.
  - Reset values: MCLK=0, SCLK=0, LRCLK=0.
- RSTn:
  - 0 in reset.
  - Rises on the clk where cnt wraps 0x3FF->0x000 for the first time, i.e. 1024 clk after rst_n deasserts. Stays 1 until the next reset.
- Frame layout:
  - Left-justified, MSB first, 16 SCLK per slot.
  - Left slot = cnt 0x200..0x3FF; right slot = cnt 0x000..0x1FF.
  - Bit index in slot = cnt[8:5].
  - SCLK rise = cnt[4:0] 0x0F->0x10; SCLK fall = 0x1F->0x00.
- Receive:
  - On clk with cnt[4:0]==0x0F, shift SDout into rx_shift[15:0] (LSB in).
  - At cnt==0x3EF (left bit 15), copy {rx_shift[14:0],SDout} to lft_hold.
  - At cnt==0x1EF (right bit 15), copy to rht_out and lft_hold->lft_out, then assert vld on the next clk (cnt==0x1F0).
- vld gating:
  - vld is suppressed until a complete frame has been received with RSTn=1: left captured after RSTn rose, then right.
  - First vld falls at clk 0x9F0 (2544) after rst_n deasserts. After that, exactly one vld per 1024 clk.
  - lft_out/rht_out reset to 0 and change only with vld.
- Transmit:
  - In the vld cycle, latch lft_in->tx_lft_hold and rht_in->tx_rht_hold (upstream presents them at vld, combinationally or held).
  - At cnt==0x1FF, load tx_shift<=tx_lft_hold. At cnt==0x3FF, load tx_shift<=tx_rht_hold. The MSB is therefore valid on SDin at the LRCLK edge.
  - On every other clk with cnt[4:0]==0x1F, tx_shift<=tx_shift<<1.
  - SDin=tx_shift[15].
  - tx holds and tx_shift reset to 0; SDin=0 in reset and until the first vld-latched data shifts out.
- Loopback latency: data latched at vld leaves on the next left/right slots. Output sample k is transmitted in frame k+1.
- Reset mid-operation: rst_n low for any clk returns cnt, RSTn, vld gating and all holds to their reset values. No partial frame is ever flagged vld.
- Simultaneous events: a load cycle (0x1FF/0x3FF) coincides with a fall event; load wins.

Decomposition:
- eq_pkg: localparams for the counter taps (RX_LFT_CAP=10'h3EF, RX_RHT_CAP=10'h1EF, TX_LFT_LD=10'h1FF, TX_RHT_LD=10'h3FF, MCLK_BIT=1, SCLK_BIT=4, LRCLK_BIT=9).
- No sub-module. The divider, rx shifter and tx shifter fit inline (~180 lines).

Test Plan:
- Reset released at t0 -> RSTn=0 for exactly 1024 clk then 1; MCLK period 4 clk, SCLK period 32 clk, LRCLK period 1024 clk, high 512.
- Codec model drives SDout left=0x1234, right=0xABCD every frame -> first vld at clk 2544; lft_out=0x1234, rht_out=0xABCD; vld period 1024 clk, width 1.
- lft_in=0x7FFF, rht_in=0x8000 held -> codec model aout_lft=32767, aout_rht=-32768, one frame after latch.
- Loop lft_out->lft_in, rht_out->rht_in with codec sine input -> aout matches ain delayed by a fixed whole number of frames, bit-exact.
- rst_n pulsed low for 1 clk at cnt=0x300 mid-frame -> RSTn=0, vld silent, SDin=0; recovery repeats first-vld timing of 2544 clk.
- SDout stuck at 1 -> lft_out=rht_out=0xFFFF (-1) on each vld; no X on any output after reset.
